// File: rtl/rs_enc_if.sv
// rs_enc_if: symbol-stream bundle between a frame source/sink and the RS encoder.
//   Input stream  (master -> slave): isop, ival, ieop, idat[m-1:0]
//   Output stream (slave -> master): ordy, osop, oval, oeop, oflag, odat[m-1:0]
// The master side drives information symbols and observes the coded stream.
// The slave side is the encoder.
interface rs_enc_if #(
  parameter int m = 8
) ();
  logic         isop;
  logic         ival;
  logic         ieop;
  logic [m-1:0] idat;
  logic         ordy;
  logic         osop;
  logic         oval;
  logic         oeop;
  logic         oflag;
  logic [m-1:0] odat;

  modport master (
    output isop, ival, ieop, idat,
    input  ordy, osop, oval, oeop, oflag, odat
  );

  modport slave (
    input  isop, ival, ieop, idat,
    output ordy, osop, oval, oeop, oflag, odat
  );
endinterface

// File: rtl/rs_enc.sv
// rs_enc: systematic Reed-Solomon encoder over GF(2^m).
// Information symbols pass through with one enabled-tick latency. After the
// last one (ieop, or the k-th symbol of a full-length frame) the encoder
// appends `check` parity symbols taken from a generator-polynomial LFSR.
// Ports:
//   iclk     clock
//   ireset   synchronous reset, active low
//   iclkena  clock enable; low freezes every register
//   bus      rs_enc_if.slave: isop/ival/ieop/idat in, ordy/osop/oval/oeop/oflag/odat out
module rs_enc #(
  parameter int m        = 8,
  parameter int irrpol   = 285,
  parameter int n        = 255,
  parameter int check    = 32,
  parameter int genstart = 0
) (
  input  logic   iclk,
  input  logic   ireset,
  input  logic   iclkena,
  rs_enc_if.slave bus
);

  localparam int k  = n - check;
  localparam int dw = $clog2(k + 1);
  localparam int pw = $clog2(check + 1);

  localparam logic [m:0] irr_poly = (m + 1)'(irrpol);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Multiply by alpha (x) with reduction by the field polynomial.
  function automatic logic [m-1:0] gf_xtime(input logic [m-1:0] a);
    logic [m:0] t;
    t = {a, 1'b0};
    t = t ^ (irr_poly & {(m + 1){t[m]}});
    return t[m-1:0];
  endfunction

  // Shift-and-add GF(2^m) multiplier.
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] acc;
    logic [m-1:0] sh;
    acc = {m{1'b0}};
    sh  = a;
    for (int i = 0; i < m; i++) begin
      acc = acc ^ (sh & {m{b[i]}});
      sh  = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Expand prod (x + alpha^(genstart+i)); the monic top term is implicit,
  // so only coefficients 0..check-1 are returned, packed low-first.
  function automatic logic [check*m-1:0] gen_poly();
    logic [m-1:0]         c [0:check];
    logic [m-1:0]         root;
    logic [check*m-1:0]   res;
    for (int j = 0; j <= check; j++) c[j] = {m{1'b0}};
    c[0] = {{(m - 1){1'b0}}, 1'b1};
    root = {{(m - 1){1'b0}}, 1'b1};
    for (int i = 0; i < genstart; i++) root = gf_xtime(root);
    for (int i = 0; i < check; i++) begin
      // descending j so c[j-1] is still the previous-round value
      for (int j = check; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
      c[0] = gf_mul(c[0], root);
      root = gf_xtime(root);
    end
    for (int j = 0; j < check; j++) res[j*m +: m] = c[j];
    return res;
  endfunction

  localparam logic [check*m-1:0] gen_coef = gen_poly();

  state_t         state_r;
  state_t         state_nxt_s;
  logic [m-1:0]   lfsr_r     [check];
  logic [m-1:0]   lfsr_nxt_s [check];
  logic [dw-1:0]  dcnt_r;
  logic [dw-1:0]  dcnt_nxt_s;
  logic [dw-1:0]  dcnt_inc_s;
  logic [pw-1:0]  pcnt_r;
  logic [pw-1:0]  pcnt_nxt_s;
  logic           ordy_r,  ordy_nxt_s;
  logic           osop_r,  osop_nxt_s;
  logic           oval_r,  oval_nxt_s;
  logic           oeop_r,  oeop_nxt_s;
  logic           oflag_r, oflag_nxt_s;
  logic [m-1:0]   odat_r,  odat_nxt_s;
  logic           acc_s;
  logic           take_s;
  logic           last_data_s;
  logic           last_par_s;
  logic [m-1:0]   fb_s;

  assign acc_s = iclkena & bus.ival & ordy_r;
  // an accepted symbol in IDLE only counts when it starts a frame
  assign take_s = acc_s & (bus.isop | (state_r == DATA));
  // isop restarts the codeword, so the LFSR is seen as cleared
  assign fb_s = bus.idat ^ (bus.isop ? {m{1'b0}} : lfsr_r[check-1]);
  assign last_par_s = (pcnt_r == pw'(check - 1));

  // Data count after the current accept; saturates at k.
  always_comb begin
    if (bus.isop) begin
      dcnt_inc_s = dw'(1'b1);
    end else if (dcnt_r == dw'(k)) begin
      dcnt_inc_s = dcnt_r;
    end else begin
      dcnt_inc_s = dcnt_r + dw'(1'b1);
    end
  end

  assign last_data_s = (dcnt_inc_s == dw'(k));

  // State register.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_r <= IDLE;
    end else if (iclkena) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DATA: begin
        if (take_s) begin
          state_nxt_s = (bus.ieop || last_data_s) ? PARITY : DATA;
        end else begin
          state_nxt_s = state_r;
        end
      end
      PARITY: begin
        if (last_par_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output and datapath next values: LFSR, counters and the output stream.
  always_comb begin
    lfsr_nxt_s  = lfsr_r;
    dcnt_nxt_s  = dcnt_r;
    pcnt_nxt_s  = pcnt_r;
    osop_nxt_s  = 1'b0;
    oval_nxt_s  = 1'b0;
    oeop_nxt_s  = 1'b0;
    oflag_nxt_s = 1'b0;
    odat_nxt_s  = {m{1'b0}};
    if (take_s) begin
      lfsr_nxt_s[0] = gf_mul(fb_s, gen_coef[0 +: m]);
      for (int i = 1; i < check; i++) begin
        lfsr_nxt_s[i] = (bus.isop ? {m{1'b0}} : lfsr_r[i-1]) ^ gf_mul(fb_s, gen_coef[i*m +: m]);
      end
      dcnt_nxt_s = dcnt_inc_s;
      pcnt_nxt_s = {pw{1'b0}};
      osop_nxt_s = bus.isop;
      oval_nxt_s = 1'b1;
      odat_nxt_s = bus.idat;
    end else if (state_r == PARITY) begin
      odat_nxt_s  = lfsr_r[check-1];
      oval_nxt_s  = 1'b1;
      oflag_nxt_s = 1'b1;
      oeop_nxt_s  = last_par_s;
      lfsr_nxt_s[0] = {m{1'b0}};
      for (int i = 1; i < check; i++) lfsr_nxt_s[i] = lfsr_r[i-1];
      if (last_par_s) begin
        pcnt_nxt_s = {pw{1'b0}};
        dcnt_nxt_s = {dw{1'b0}};
      end else begin
        pcnt_nxt_s = pcnt_r + pw'(1'b1);
      end
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
    ordy_nxt_s = (state_nxt_s != PARITY);
  end

  // Datapath and output registers.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      for (int i = 0; i < check; i++) lfsr_r[i] <= {m{1'b0}};
      dcnt_r  <= {dw{1'b0}};
      pcnt_r  <= {pw{1'b0}};
      ordy_r  <= 1'b1;
      osop_r  <= 1'b0;
      oval_r  <= 1'b0;
      oeop_r  <= 1'b0;
      oflag_r <= 1'b0;
      odat_r  <= {m{1'b0}};
    end else if (iclkena) begin
      lfsr_r  <= lfsr_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
      ordy_r  <= ordy_nxt_s;
      osop_r  <= osop_nxt_s;
      oval_r  <= oval_nxt_s;
      oeop_r  <= oeop_nxt_s;
      oflag_r <= oflag_nxt_s;
      odat_r  <= odat_nxt_s;
    end
  end

  assign bus.ordy  = ordy_r;
  assign bus.osop  = osop_r;
  assign bus.oval  = oval_r;
  assign bus.oeop  = oeop_r;
  assign bus.oflag = oflag_r;
  assign bus.odat  = odat_r;

endmodule

// File: doc/rs_enc.md
Name: rs_enc

Overview:
- Systematic Reed-Solomon encoder over GF(2^m); the transmit-side counterpart of the RS decoder datapath (syndrome, key-equation solver, Chien/Forney with GF divider).
- Accepts a frame of information symbols and passes them through with 1-tick latency.
- Appends `check` parity symbols computed by a generator-polynomial LFSR.
- Supports full-length and shortened codes; the frame end is marked by `ieop` or by reaching the maximum data count.

Parameters:
- m, 8, symbol width in bits, GF(2^m).
- irrpol, 285, field primitive polynomial.
- n, 255, full codeword length in symbols (≤ 2^m-1).
- check, 32, parity symbols per codeword (2t).
- genstart, 0, power of first generator root: g(x)=Π_{i=0..check-1}(x-α^(genstart+i)).

Ports:
- iclk     in   1  clock
- ireset   in   1  synchronous reset, active-low (reset when ireset=0 at posedge iclk)
- iclkena  in   1  clock enable; 0 freezes all state and outputs
- isop     in   1  first symbol of frame
- ival     in   1  input symbol valid
- ieop     in   1  last information symbol of frame
- idat     in   m  information symbol
- ordy     out  1  encoder accepts input this cycle
- osop     out  1  first output symbol of codeword
- oval     out  1  output symbol valid
- oeop     out  1  last parity symbol of codeword
- oflag    out  1  1 = current output is a parity symbol
- odat     out  m  output symbol

Behaviour:
- Generator coefficients g[0..check-1] are computed at elaboration from irrpol, genstart and check. They are constants; there is no run-time ROM load.
- Accept condition: acc = iclkena & ival & ordy.
- Reset (ireset=0): state IDLE, LFSR r[0..check-1]=0, data counter=0, parity counter=0, ordy=1, osop=oval=oeop=oflag=0, odat=0.
- States:
  - IDLE: ordy=1. acc & isop → DATA (or PARITY if ieop, or if k=n-check=1). acc without isop → ignored, no output.
  - DATA: ordy=1. Each acc shifts the LFSR and increments the counter. acc & ieop, or acc on symbol number k=n-check, → PARITY. acc & isop → abort the current frame: clear LFSR/counter, treat the symbol as the first of a new frame; no parity is emitted for the aborted frame.
  - PARITY: ordy=0; inputs ignored. Each iclkena cycle emits one parity symbol. After `check` symbols → IDLE, and ordy=1 on the next cycle.
- LFSR update on acc:
  - fb = idat ^ r[check-1]
  - r[0] ← fb·g[0]
  - r[i] ← r[i-1] ^ fb·g[i]
  - The first symbol of a frame uses r=0 (isop forces the cleared value).
- Parity output order: r[check-1] first. Each parity cycle shifts r[i] ← r[i-1], r[0] ← 0. The LFSR is all-zero at the end of PARITY.
- Output timing: registered, latency 1 iclkena tick.
  - Data phase: odat=idat, oval=1, oflag=0, osop=isop of the accepted symbol.
  - Parity phase: oval=1, oflag=1; oeop=1 only on the last parity symbol.
  - oval=0 in cycles with no acc and no parity emission.
- The output stream is contiguous from the first parity symbol through oeop, provided iclkena stays high. iclkena=0 pauses it with no loss.
- Back-to-back frames: new isop is accepted on the first cycle after oeop is emitted. Minimum gap is 0 idle cycles beyond ordy.
- Reset mid-frame, or mid-parity, returns to the reset state on the next edge. No partial oeop is emitted.
- Counters:
  - data counter is ceil(log2(n-check+1)) bits and saturates at k.
  - parity counter is ceil(log2(check+1)) bits.

Test Plan:
Test parameters: m=4, irrpol=19, n=15, check=4, genstart=1, giving RS(15,11) with g = x^4 + 13x^3 + 12x^2 + 8x + 7 (α^13, α^6, α^3, α^10).
1. 11 zero symbols with isop on the first → 11 zeros out (oflag=0), then parity 0,0,0,0 with oflag=1 and oeop on the 4th; ordy low for exactly 4 cycles.
2. Data 0×10 then 1 (full length, no ieop) → data echoed, then parity 13,12,8,7; osop on output 1, oeop on output 15.
3. Shortened frame: a single symbol 1 with isop=ieop=1 → output 1 (osop, oflag=0), then parity 13,12,8,7 (oeop on 7).
4. Abort: isop, data 5,3, then isop with data 1 and ieop → parity 13,12,8,7 only for the second frame; no oeop for the first frame.
5. Toggle iclkena with a 50% random pattern during case 2 → identical symbol sequence on oval-qualified cycles.
6. Drive ireset=0 during the 2nd parity symbol → all outputs 0 and ordy=1 the next cycle; a following case-3 frame gives 1,13,12,8,7.
